wb_byte_loader: RTL and testbench

Wishbone initiator that turns a byte stream (boot UART, debug link) into word writes to a Wishbone memory, e.g. the on-chip program RAM. Bytes are packed little-endian into 32-bit words and written at an auto-incrementing word address. A final partial word is written with a matching byte-select mask. The block sits between the stream source and the memory's Wishbone port and owns the bus while a load is in progress.

---
 rtl/wb_byte_loader.sv | 152 +++++++++++++++
 tb/tb_wb_byte_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_loader.sv
// rtl/wb_byte_loader.sv - byte stream to Wishbone word-write loader
// Packs bytes little-endian into 32-bit words and writes them at an auto-incrementing address.
module wb_byte_loader #(
  parameter int depth       = 256,
  parameter int aw          = $clog2(depth),
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [aw-3:0] i_base_adr,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_valid,
  input  logic          i_byte_last,
  output logic          o_byte_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_e;

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   buf_q, buf_d;
  logic [3:0]    sel_q, sel_d;
  logic [aw-3:0] adr_q, adr_d;
  logic          last_q, last_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      buf_q   <= '0;
      sel_q   <= '0;
      adr_q   <= '0;
      last_q  <= 1'b0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          adr_d   = i_base_adr;
          lane_d  = '0;
          buf_d   = '0;
          sel_d   = '0;
          last_d  = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (i_byte_valid) begin
          buf_d[{lane_q, 3'b000} +: 8] = i_byte;
          sel_d[lane_q]                = 1'b1;
          if (lane_q == 2'd3 || i_byte_last) begin
            last_d  = i_byte_last;
            lane_d  = '0;
            tmo_d   = '0;
            state_d = WRITE;
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      WRITE: begin
        if (i_wb_ack) begin
          adr_d = adr_q + (aw-2)'(1);
          buf_d = '0;
          sel_d = '0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = COLLECT;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abort: address stays put, partial load is dropped
          buf_d   = '0;
          sel_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_byte_ready = 1'b0;
    o_busy       = 1'b0;
    o_wb_cyc     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_dat     = '0;
    o_wb_sel     = '0;
    case (state_q)
      COLLECT: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
      WRITE: begin
        o_busy   = 1'b1;
        o_wb_cyc = 1'b1;
        o_wb_we  = 1'b1;
        o_wb_dat = buf_q;
        o_wb_sel = sel_q;
      end
      default: ;
    endcase
  end

  assign o_wb_adr = adr_q;
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_wb_byte_loader.sv
// tb/tb_wb_byte_loader.sv - directed self-checking bench for wb_byte_loader
module tb_wb_byte_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-3:0] i_base_adr = '0;
  logic [7:0]    i_byte = '0;
  logic          i_byte_valid = 1'b0;
  logic          i_byte_last = 1'b0;
  logic          o_byte_ready, o_busy, o_done, o_err, o_wb_we, o_wb_cyc;
  logic [AW-3:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          ack;
  logic          ack_en = 1'b1;

  int total = 0;
  int bad = 0;

  wb_byte_loader #(.depth(256), .ACK_TIMEOUT(16)) dut (
    .i_wb_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_base_adr(i_base_adr),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .i_byte_last(i_byte_last),
    .o_byte_ready(o_byte_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .i_wb_ack(ack)
  );

  always #5 clk = ~clk;

  // Slave acks cyc & !ack, giving two cycles of cyc per word
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack <= 1'b0;
    else        ack <= ack_en & o_wb_cyc & ~ack;
  end

  logic [31:0] mon_adr[$];
  logic [31:0] mon_dat[$];
  logic [31:0] mon_sel[$];
  int          mon_len[$];
  int          run = 0;
  int          last_run = 0;
  int          ready_in_write = 0;

  always @(negedge clk) begin
    if (o_wb_cyc) begin
      run++;
      if (o_byte_ready) ready_in_write++;
      if (ack) begin
        mon_adr.push_back(32'(o_wb_adr));
        mon_dat.push_back(o_wb_dat);
        mon_sel.push_back(32'(o_wb_sel));
        mon_len.push_back(run);
        run = 0;
      end
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_adr.delete(); mon_dat.delete(); mon_sel.delete(); mon_len.delete();
    ready_in_write = 0;
  endtask

  task automatic start_load(input logic [AW-3:0] base);
    @(negedge clk);
    i_start = 1'b1;
    i_base_adr = base;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Valid stays high between bytes so stalls during WRITE are exercised
  task automatic push_bytes(input int n, input logic [7:0] first, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      int guard;
      i_byte = first + 8'(i) * step;
      i_byte_valid = 1'b1;
      i_byte_last = (i == n - 1);
      guard = 0;
      while (!o_byte_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) chk("ready_timeout", 32'(guard), 32'd0);
      @(negedge clk);
    end
    i_byte_valid = 1'b0;
    i_byte_last = 1'b0;
  endtask

  task automatic wait_end(output int done_n, output int err_n);
    done_n = 0;
    err_n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_done) done_n++;
      if (o_err) err_n++;
      if ((done_n + err_n) != 0 && !o_done && !o_err) break;
    end
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [31:0] sel);
    chk({tag, "_adr"}, mon_adr[idx], adr);
    chk({tag, "_dat"}, mon_dat[idx], dat);
    chk({tag, "_sel"}, mon_sel[idx], sel);
    chk({tag, "_cyclen"}, 32'(mon_len[idx]), 32'd2);
  endtask

  initial begin
    int dn, en;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_ready", 32'(o_byte_ready), 32'd0);
    chk("rst_sel", 32'(o_wb_sel), 32'd0);
    chk("rst_adr", 32'(o_wb_adr), 32'd0);
    chk("rst_done_err", 32'({o_done, o_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two full words
    clear_mon();
    start_load(6'h10);
    push_bytes(8, 8'h11, 8'h11);
    wait_end(dn, en);
    chk("t1_nwrites", 32'(mon_adr.size()), 32'd2);
    chk_write("t1_w0", 0, 32'h10, 32'h44332211, 32'hF);
    chk_write("t1_w1", 1, 32'h11, 32'h88776655, 32'hF);
    chk("t1_done_width", 32'(dn), 32'd1);
    chk("t1_err", 32'(en), 32'd0);
    chk("t1_busy_after", 32'(o_busy), 32'd0);
    chk("t1_ready_in_write", 32'(ready_in_write), 32'd0);

    // Partial final word, last byte on lane 0
    clear_mon();
    start_load(6'h20);
    push_bytes(5, 8'h01, 8'h01);
    wait_end(dn, en);
    chk("t2_nwrites", 32'(mon_adr.size()), 32'd2);
    chk_write("t2_w0", 0, 32'h20, 32'h04030201, 32'hF);
    chk_write("t2_w1", 1, 32'h21, 32'h00000005, 32'h1);
    chk("t2_done_width", 32'(dn), 32'd1);

    // Address wrap at depth/4
    clear_mon();
    start_load(6'd63);
    push_bytes(8, 8'hA0, 8'h01);
    wait_end(dn, en);
    chk("t3_nwrites", 32'(mon_adr.size()), 32'd2);
    chk_write("t3_w0", 0, 32'd63, 32'hA3A2A1A0, 32'hF);
    chk_write("t3_w1", 1, 32'd0, 32'hA7A6A5A4, 32'hF);
    chk("t3_ready_in_write", 32'(ready_in_write), 32'd0);

    // Start pulse while collecting is ignored; 2-byte partial word
    clear_mon();
    start_load(6'h08);
    i_start = 1'b1;
    i_base_adr = 6'h3F;
    @(negedge clk);
    i_start = 1'b0;
    push_bytes(2, 8'h55, 8'h01);
    wait_end(dn, en);
    chk("t4_nwrites", 32'(mon_adr.size()), 32'd1);
    chk_write("t4_w0", 0, 32'h08, 32'h00005655, 32'h3);

    // Ack timeout
    clear_mon();
    ack_en = 1'b0;
    start_load(6'h05);
    push_bytes(4, 8'hC0, 8'h01);
    wait_end(dn, en);
    chk("t5_err_width", 32'(en), 32'd1);
    chk("t5_done", 32'(dn), 32'd0);
    chk("t5_cyc_len", 32'(last_run), 32'd16);
    chk("t5_nwrites", 32'(mon_adr.size()), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_ready", 32'(o_byte_ready), 32'd0);
    chk("t5_adr_held", 32'(o_wb_adr), 32'h05);
    ack_en = 1'b1;
    start_load(6'h06);
    push_bytes(4, 8'hD0, 8'h01);
    wait_end(dn, en);
    chk("t5_restart_done", 32'(dn), 32'd1);
    chk_write("t5_w0", 0, 32'h06, 32'hD3D2D1D0, 32'hF);

    // Asynchronous reset in the middle of a write
    clear_mon();
    ack_en = 1'b0;
    start_load(6'h12);
    push_bytes(4, 8'hE0, 8'h01);
    for (int g = 0; g < 20 && !o_wb_cyc; g++) @(negedge clk);
    chk("t6_cyc_before", 32'(o_wb_cyc), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("t6_rst_we", 32'(o_wb_we), 32'd0);
    chk("t6_rst_sel", 32'(o_wb_sel), 32'd0);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_ready_idle", 32'(o_byte_ready), 32'd0);
    chk("t6_nwrites", 32'(mon_adr.size()), 32'd0);
    start_load(6'h30);
    push_bytes(4, 8'h0A, 8'h01);
    wait_end(dn, en);
    chk("t6_done", 32'(dn), 32'd1);
    chk_write("t6_w0", 0, 32'h30, 32'h0D0C0B0A, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
